// File: rtl/universal_reg.sv
// WIDTH-bit edge-triggered register with load, shift, rotate and count modes,
// a registered complement output and a one-cycle carry/bit-out flag.
module universal_reg #(
    parameter int unsigned          WIDTH   = 8,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             co
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qn_q;
    logic             co_q, co_d;

    // One extra bit holds the carry (increment) or borrow (decrement).
    logic [WIDTH:0] inc_sum;
    logic [WIDTH:0] dec_diff;

    always_comb begin
        inc_sum  = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
        dec_diff = {1'b0, q_q} - {{WIDTH{1'b0}}, 1'b1};
    end

    always_comb begin
        q_d  = q_q;
        co_d = 1'b0;
        if (en) begin
            unique case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: q_d = d;
                MODE_SHL: begin
                    q_d  = {q_q[WIDTH-2:0], sin_r};
                    co_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d  = {sin_l, q_q[WIDTH-1:1]};
                    co_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    co_d = q_q[WIDTH-1];
                end
                MODE_ROR: begin
                    q_d  = {q_q[0], q_q[WIDTH-1:1]};
                    co_d = q_q[0];
                end
                MODE_INC: begin
                    q_d  = inc_sum[WIDTH-1:0];
                    co_d = inc_sum[WIDTH];
                end
                MODE_DEC: begin
                    q_d  = dec_diff[WIDTH-1:0];
                    co_d = dec_diff[WIDTH];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q  <= RST_VAL;
            qn_q <= ~RST_VAL;
            co_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            qn_q <= ~q_d;
            co_q <= co_d;
        end
    end

    assign q  = q_q;
    assign qn = qn_q;
    assign co = co_q;

endmodule

// File: tb/tb_universal_reg.sv
// Directed bench for universal_reg: two instances (RST_VAL 00 and A5) share stimulus.
module tb_universal_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] q, qn, q2, qn2;
    logic       co, co2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    universal_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l), .q(q), .qn(qn), .co(co)
    );

    universal_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut_a5 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l), .q(q2), .qn(qn2), .co(co2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] eq, input logic ec);
        check_eq({tag, ".q"}, {24'h0, q}, {24'h0, eq});
        check_eq({tag, ".qn"}, {24'h0, qn}, {24'h0, ~eq});
        check_eq({tag, ".co"}, {31'h0, co}, {31'h0, ec});
    endtask

    task automatic load(input logic [7:0] v);
        en = 1'b1; mode = 3'b001; d = v;
        step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 3'b001; d = 8'hFF; sin_r = 1'b0; sin_l = 1'b0;
        step(); step();
        chk("reset", 8'h00, 1'b0);
        check_eq("reset_a5.q", {24'h0, q2}, 32'hA5);
        check_eq("reset_a5.qn", {24'h0, qn2}, 32'h5A);
        check_eq("reset_a5.co", {31'h0, co2}, 32'h0);

        rst = 1'b0;
        load(8'h3C);
        chk("load3c", 8'h3C, 1'b0);
        mode = 3'b000; d = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold", 8'h3C, 1'b0);
        end
        en = 1'b0; mode = 3'b110;
        step();
        chk("disabled", 8'h3C, 1'b0);

        load(8'b1000_0001);
        en = 1'b1; mode = 3'b010; sin_r = 1'b1;
        step();
        chk("shl", 8'b0000_0011, 1'b1);
        mode = 3'b011; sin_l = 1'b0;
        step();
        chk("shr1", 8'b0000_0001, 1'b1);
        step();
        chk("shr2", 8'h00, 1'b1);
        // Change d between edges while holding: must not leak through.
        mode = 3'b000; #2 d = 8'h77;
        step();
        chk("hold_after_shr", 8'h00, 1'b0);

        load(8'h81);
        mode = 3'b100;
        step();
        chk("rol", 8'h03, 1'b1);
        mode = 3'b101;
        step();
        chk("ror1", 8'h81, 1'b1);
        step();
        chk("ror2", 8'hC0, 1'b1);

        load(8'hFE);
        chk("loadfe", 8'hFE, 1'b0);
        mode = 3'b110;
        step(); chk("inc1", 8'hFF, 1'b0);
        step(); chk("inc2", 8'h00, 1'b1);
        step(); chk("inc3", 8'h01, 1'b0);
        mode = 3'b111;
        step(); chk("dec1", 8'h00, 1'b0);
        step(); chk("dec2", 8'hFF, 1'b1);
        load(8'h55);
        chk("load_clears_co", 8'h55, 1'b0);

        load(8'h10);
        mode = 3'b110;
        step(); step();
        chk("count12", 8'h12, 1'b0);
        rst = 1'b1;
        step();
        chk("rst_mid", 8'h00, 1'b0);
        check_eq("rst_mid_a5.q", {24'h0, q2}, 32'hA5);
        rst = 1'b0;
        step();
        chk("after_rst", 8'h01, 1'b0);
        check_eq("after_rst_a5.q", {24'h0, q2}, 32'hA6);
        check_eq("after_rst_a5.qn", {24'h0, qn2}, 32'h59);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
